// File: rtl/fpu_defines_pkg.sv
// rtl/fpu_defines_pkg.sv - FPU operation identifiers shared by the FPU bank
package fpu_defines_pkg;

  typedef enum logic [3:0] {
    NOOP      = 4'd0,
    LINEAR_FW = 4'd1,
    LINEAR_BW = 4'd2,
    CONV_FW   = 4'd3,
    ADD       = 4'd4,
    MUL       = 4'd5
  } op_id;

endpackage

// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - job descriptor types and slot states for the FPU job scheduler
package fpu_sched_pkg;

  import fpu_defines_pkg::op_id;

  localparam int REGION_W = 23;

  typedef struct packed {
    logic [REGION_W-1:0] region_begin;
    logic [REGION_W-1:0] region_end;
  } fpu_region_t;

  typedef struct packed {
    op_id        op;
    fpu_region_t a;
    fpu_region_t b;
    fpu_region_t c;
    fpu_region_t d;
  } fpu_job_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } slot_state_e;

endpackage

// File: rtl/fpu_job_fifo.sv
// rtl/fpu_job_fifo.sv - synchronous job FIFO with registered storage and head read
module fpu_job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + AW'(1);
      if (pop_en)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_job_scheduler.sv
// rtl/fpu_job_scheduler.sv - round-robin dispatch of queued FPU jobs to NUM_JM job managers
// Optional FPU_SCHED_STATS_EN adds saturating stall_cycles/busy_cycles counters.
module fpu_job_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_JM     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  fpu_job_t              job_in,
  output logic [NUM_JM-1:0]     jm_avail,
  output fpu_job_t [NUM_JM-1:0] jm_job,
  input  logic [NUM_JM-1:0]     jm_done,
  output logic                  idle,
  output logic [15:0]           jobs_done
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           busy_cycles
`endif
);

  localparam int PW = (NUM_JM > 1) ? $clog2(NUM_JM) : 1;
  localparam int JW = $bits(fpu_job_t);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  slot_state_e           state_q [NUM_JM];
  slot_state_e           state_d [NUM_JM];
  fpu_job_t [NUM_JM-1:0] job_q;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         rr_d;
  logic [PW-1:0]         sel;
  logic [PW-1:0]         idx;
  logic [NUM_JM-1:0]     idle_mask;
  logic                  found;
  logic                  dispatch;
  logic                  all_idle;
  logic [3:0]            n_done;
  logic [15:0]           jobs_done_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [JW-1:0]         fifo_head;

  fpu_job_fifo #(
    .WIDTH (JW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (job_valid),
    .data_i  (job_in),
    .pop_i   (dispatch),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NUM_JM; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_JM) j = j - NUM_JM;
      idx = PW'(j);
      if (!found && idle_mask[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign dispatch = found && !fifo_empty;

  always_comb begin
    rr_d = rr_q;
    if (dispatch) rr_d = (int'(sel) == NUM_JM - 1) ? '0 : sel + PW'(1);
  end

  // DRAIN is the mandatory low cycle of avail between two jobs on the same manager.
  always_comb begin
    n_done   = '0;
    all_idle = 1'b1;
    for (int i = 0; i < NUM_JM; i++) begin
      state_d[i]   = state_q[i];
      idle_mask[i] = (state_q[i] == IDLE);
      jm_avail[i]  = (state_q[i] == RUN);
      if (state_q[i] != IDLE) all_idle = 1'b0;
      case (state_q[i])
        IDLE: if (dispatch && sel == PW'(i)) state_d[i] = RUN;
        RUN: begin
          if (jm_done[i]) begin
            state_d[i] = DRAIN;
            n_done     = n_done + 4'd1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_JM; i++) state_q[i] <= IDLE;
      job_q       <= '0;
      rr_q        <= '0;
      jobs_done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_JM; i++) state_q[i] <= state_d[i];
      if (dispatch) job_q[sel] <= fifo_head;
      rr_q        <= rr_d;
      jobs_done_q <= jobs_done_q + 16'(n_done);
    end
  end

  assign jm_job    = job_q;
  assign jobs_done = jobs_done_q;
  assign job_ready = !fifo_full;
  assign idle      = (fifo_count == '0) && all_idle;

`ifdef FPU_SCHED_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] busy_q;
  logic        any_run;

  always_comb begin
    any_run = 1'b0;
    for (int i = 0; i < NUM_JM; i++) begin
      if (state_q[i] == RUN) any_run = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      busy_q  <= '0;
    end else begin
      if (any_run && busy_q != '1) busy_q <= busy_q + 32'd1;
      if (!fifo_empty && !found && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign busy_cycles  = busy_q;
`endif

endmodule

// File: doc/fpu_job_scheduler.md
# fpu_job_scheduler

Dispatches queued FPU jobs (operation plus four memory-region descriptors) across a bank of `NUM_JM` FPU job managers. Incoming jobs are buffered in a FIFO and handed to free managers in round-robin order. The scheduler drives each manager's `avail`/`done` handshake and reports completion. It sits between the layer sequencer and the FPU bank, replacing the bank's single hard-wired job manager connection.

## Interface
Parameters:
- `NUM_JM`, 4: number of FPU job managers served (1–8).
- `FIFO_DEPTH`, 8: job queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `job_valid`  in  1  requester presents a job.
- `job_ready`  out  1  scheduler accepts the job this cycle.
- `job_in`  in  `$bits(fpu_job_t)`  job descriptor: `op`, plus `region_begin`/`region_end` (23 b each) for a, b, c, d.
- `jm_avail`  out  `NUM_JM`  per-manager start/hold.
- `jm_job`  out  `NUM_JM`×`fpu_job_t`  per-manager descriptor; stable while `jm_avail[i]` is high.
- `jm_done`  in  `NUM_JM`  per-manager completion.
- `idle`  out  1  FIFO empty and all slots in IDLE.
- `jobs_done`  out  16  completed-job count; wraps at 2^16.
- `stall_cycles`, `busy_cycles`  out  32 each  present only with `FPU_SCHED_STATS_EN`.

## Operation
- **Accept.** A job is pushed on a clock edge where `job_valid && job_ready`. `job_ready = !full`. A pop in the same cycle does not free space for the push.
- **Slot FSM, one per manager:**
  - IDLE → RUN when dispatched. On the same edge, `jm_avail[i]` goes 1 and `jm_job[i]` is loaded.
  - RUN → DRAIN on the edge where `jm_done[i]` is sampled high. On that edge, `jm_avail[i]` goes 0 and `jobs_done` increments.
  - DRAIN → IDLE unconditionally on the next edge. This guarantees at least one low cycle of `avail` between jobs.
- **Dispatch.**
  - At most one dispatch per cycle.
  - Dispatch happens when the FIFO is non-empty and at least one slot is IDLE.
  - The chosen slot is the first IDLE slot at or after `rr_ptr`, searching with wrap-around.
  - After a dispatch, `rr_ptr` becomes chosen+1 mod `NUM_JM`. Otherwise it holds.
- `jm_done[i]` is ignored outside RUN.
- The job op is never interpreted; it is passed through unchanged. `NOOP` jobs are dispatched like any other.
- `idle` is combinational from the FIFO count and the slot states.
- **Reset, including mid-job:** FIFO emptied, queued and running jobs discarded, all slots IDLE, `rr_ptr` = 0, `jm_avail` = 0, `jm_job` = 0, `jobs_done` = 0, stat counters = 0. Outputs after reset: `job_ready` = 1, `idle` = 1.

## Timing
- Push at edge k: the job is at the FIFO head after edge k. The earliest `jm_avail` rise is at edge k+1, so dispatch latency is 2 edges from push.
- Completion: `jm_done` sampled at edge m gives `jm_avail` low after edge m and the slot dispatchable at edge m+2.
- Sustained throughput is one dispatch per cycle while free slots exist.
- The FIFO has no bypass. An empty FIFO never forwards `job_in` in the same cycle.

## Configuration
- `FPU_SCHED_STATS_EN` defined:
  - `busy_cycles` increments every cycle any slot is in RUN.
  - `stall_cycles` increments every cycle the FIFO is non-empty and no slot is IDLE.
  - Both saturate at 2^32−1.
- `FPU_SCHED_STATS_EN` not defined: the counters and both ports are absent.

## Structure
- Shared package `fpu_sched_pkg`, which imports `op_id` from the FPU defines, holds:
  - `fpu_region_t` (`region_begin`, `region_end`, 23 b each).
  - `fpu_job_t` (`op`, plus `fpu_region_t` a, b, c, d).
  - The slot-state enum: IDLE, RUN, DRAIN.
- Sub-module `fpu_job_fifo`: parameterised synchronous FIFO with registered head, push/pop, `full`/`empty`/`count`, and async active-high reset.

## Test plan
- **Reset and single job.** Reset, then push one LINEAR_FW job. Expect `jm_avail[0]` = 1 two edges after the push, `jm_job[0]` equal to the pushed descriptor, and `idle` = 0. Pulse `jm_done[0]`. Expect `avail[0]` low on the next edge, `jobs_done` = 1, and `idle` = 1 one edge later.
- **Round-robin.** `NUM_JM` = 4, push 6 jobs back-to-back. Expect slots 0, 1, 2, 3 dispatched on consecutive edges and the remaining 2 held. Complete slot 2, then slot 0. Expect job 5 on slot 2 (after the DRAIN cycle) and job 6 on slot 0.
- **FIFO full.** With all slots in RUN, push 8 jobs. Expect `job_ready` = 0 after the 8th. A push attempted on the same edge as a pop must be refused, leaving the count at 8. `stall_cycles` counts each waiting cycle.
- **Spurious done.** Assert `jm_done[3]` while slot 3 is IDLE. Expect no change to `jobs_done` and no state change.
- **Reset mid-operation.** Assert `rst` with 2 slots running and 3 jobs queued. Expect all `jm_avail` = 0 immediately (asynchronous), FIFO empty, and `jobs_done` = 0. After reset release, expect the next push to go to slot 0.
- **Wrap-around.** Force `jobs_done` to 0xFFFF, complete one job, and expect 0x0000.
